// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_pkg: shared constants and FSM encoding for the fetch PC sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam int          c_default_width       = 32;
  localparam logic [31:0] c_default_reset_pc    = 32'h0000_0000;
  localparam logic [31:0] c_default_pc_step     = 32'd4;
  localparam logic [31:0] c_default_trap_vector = 32'h0000_0080;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// +----------------------------------------------------------------------------+
// | pc_next_mux: priority select of the next PC (halt > jump > branch >       |
// | stall > sequential). Honours macro PC_MISALIGN_TRAP_EN.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_next_mux
  import fetch_pkg::*;
#(
  parameter int               WIDTH       = c_default_width,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(c_default_trap_vector)
) (
  input  logic [WIDTH-1:0] pc_cur,
  input  logic [WIDTH-1:0] add_out,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt_req,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic             stall,
  output logic [WIDTH-1:0] next_pc,
  output logic             redirect,
  output logic             bad_target
);

  logic [WIDTH-1:0] w_target;

  always_comb begin
    w_target   = jump ? jump_target : branch_target;
    redirect   = !halt_req && (jump || branch_taken);
    bad_target = 1'b0;
    next_pc    = add_out;
    if (halt_req) begin
      next_pc = pc_cur;
    end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (w_target[1:0] != 2'b00) begin
        next_pc    = TRAP_VECTOR;
        bad_target = 1'b1;
      end else begin
        next_pc = w_target;
      end
`else
      next_pc = {w_target[WIDTH-1:2], 2'b00};
`endif
    end else if (stall) begin
      next_pc = pc_cur;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | fetch_pc_sequencer: owns the fetch PC, drives the PC+STEP adder and       |
// | arbitrates halt/jump/branch/stall. Honours macro PC_MISALIGN_TRAP_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter int               WIDTH       = c_default_width,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(c_default_reset_pc),
  parameter logic [WIDTH-1:0] PC_STEP     = WIDTH'(c_default_pc_step),
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(c_default_trap_vector)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt_req,
  input  logic [WIDTH-1:0] add_out,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] npc_out,
  output logic             if_valid,
  output logic             flush_ifid,
  output logic             halted,
  output logic             misalign
);

  fetch_state_t     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, r_npc, w_pc_nxt, w_npc_nxt;
  logic             r_if_valid, r_flush, r_misalign;
  logic             w_if_valid_nxt, w_flush_nxt, w_misalign_nxt;
  logic [WIDTH-1:0] w_mux_pc;
  logic             w_redirect, w_bad_target;

  pc_next_mux #(
    .WIDTH       (WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_next_mux (
    .pc_cur        (r_pc),
    .add_out       (add_out),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .next_pc       (w_mux_pc),
    .redirect      (w_redirect),
    .bad_target    (w_bad_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_npc      <= '0;
      r_if_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_npc      <= w_npc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_flush    <= w_flush_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // BOOT and HALT never advance the PC; only RUN/STALL consult the mux.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_npc_nxt      = r_npc;
    w_if_valid_nxt = 1'b0;
    w_flush_nxt    = 1'b0;
    w_misalign_nxt = r_misalign;
    case (r_state)
      S_BOOT: w_state_nxt = halt_req ? S_HALT : S_RUN;
      S_RUN, S_STALL: begin
        if (halt_req) begin
          w_state_nxt = S_HALT;
        end else if (w_redirect) begin
          w_state_nxt    = S_RUN;
          w_pc_nxt       = w_mux_pc;
          w_flush_nxt    = 1'b1;
          w_misalign_nxt = r_misalign | w_bad_target;
        end else if (stall) begin
          w_state_nxt = S_STALL;
        end else begin
          w_state_nxt    = S_RUN;
          w_pc_nxt       = w_mux_pc;
          w_npc_nxt      = w_mux_pc;
          w_if_valid_nxt = 1'b1;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign add_a      = r_pc;
  assign add_b      = PC_STEP;
  assign pc_out     = r_pc;
  assign npc_out    = r_npc;
  assign if_valid   = r_if_valid;
  assign flush_ifid = r_flush;
  assign halted     = (r_state == S_HALT);
  // Without the trap feature w_bad_target is constant 0, so this is tied low.
  assign misalign   = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_pc_sequencer: scoreboard bench for fetch_pc_sequencer.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, halt_req = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] add_out, add_a, add_b, pc_out, npc_out;
  logic        if_valid, flush_ifid, halted, misalign;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    bit          cn;
    bit          v;
    bit          f;
    bit          h;
    bit          m;
  } exp_t;

  typedef struct {
    bit          j;
    logic [31:0] jt;
    bit          b;
    logic [31:0] bt;
    bit          s;
    bit          hr;
    exp_t        e;
  } stim_t;

  stim_t st[$];
  exp_t  sb[$];

  // Bench-side model of the external PC+4 adder.
  assign add_out = add_a + 32'd4;

  always #5 clk = ~clk;

  fetch_pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .add_out       (add_out),
    .add_a         (add_a),
    .add_b         (add_b),
    .pc_out        (pc_out),
    .npc_out       (npc_out),
    .if_valid      (if_valid),
    .flush_ifid    (flush_ifid),
    .halted        (halted),
    .misalign      (misalign)
  );

  function automatic stim_t mk(bit j, logic [31:0] jt, bit b, logic [31:0] bt, bit s, bit hr,
                               logic [31:0] pc, logic [31:0] npc, bit cn, bit v, bit f, bit h, bit m);
    stim_t r;
    r.j = j; r.jt = jt; r.b = b; r.bt = bt; r.s = s; r.hr = hr;
    r.e.pc = pc; r.e.npc = npc; r.e.cn = cn; r.e.v = v; r.e.f = f; r.e.h = h; r.e.m = m;
    return r;
  endfunction

  function automatic stim_t idle(logic [31:0] pc, bit m);
    return mk(0, 0, 0, 0, 0, 0, pc, pc, 1, 1, 0, 0, m);
  endfunction

  task automatic apply_reset();
    {stall, branch_taken, jump, halt_req} = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    {stall, branch_taken, jump, halt_req} = '0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({pc_out, npc_out, add_a, add_b, if_valid, flush_ifid, halted, misalign} !==
        {32'h0, 32'h0, 32'h0, 32'd4, 4'b0000})
      $display("FAIL reset_values: pc=%h npc=%h a=%h b=%h v=%b f=%b h=%b m=%b required pc=0 npc=0 a=0 b=4 flags=0",
               pc_out, npc_out, add_a, add_b, if_valid, flush_ifid, halted, misalign);
    else passed++;
    rst_n = 1'b1;
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0));
    st.push_back(idle(32'h4, 0));
    st.push_back(idle(32'h8, 0));
    st.push_back(idle(32'hC, 0));
    for (int k = 0; st.size() > 0; k++) begin
      stim_t s_ = st.pop_front();
      exp_t  e;
      {jump, jump_target, branch_taken, branch_target, stall, halt_req} = {s_.j, s_.jt, s_.b, s_.bt, s_.s, s_.hr};
      sb.push_back(s_.e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_out, add_a, add_b, if_valid, flush_ifid, halted, misalign} !== {e.pc, e.pc, 32'd4, e.v, e.f, e.h, e.m})
        $display("FAIL boot_seq[%0d]: pc=%h a=%h b=%h vfhm=%b%b%b%b required pc=%h a=%h b=4 vfhm=%b%b%b%b",
                 k, pc_out, add_a, add_b, if_valid, flush_ifid, halted, misalign, e.pc, e.pc, e.v, e.f, e.h, e.m);
      else passed++;
      if (e.cn) begin
        checks++;
        if (npc_out !== e.npc) $display("FAIL boot_npc[%0d]: npc=%h required %h", k, npc_out, e.npc);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0));
    st.push_back(idle(32'h4, 0));
    st.push_back(idle(32'h8, 0));
    for (int i = 0; i < 3; i++) st.push_back(mk(0, 0, 0, 0, 1, 0, 32'h8, 32'h8, 1, 0, 0, 0, 0));
    st.push_back(idle(32'hC, 0));
    for (int k = 0; st.size() > 0; k++) begin
      stim_t s_ = st.pop_front();
      exp_t  e;
      {jump, jump_target, branch_taken, branch_target, stall, halt_req} = {s_.j, s_.jt, s_.b, s_.bt, s_.s, s_.hr};
      sb.push_back(s_.e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_out, if_valid, flush_ifid, halted, misalign} !== {e.pc, e.v, e.f, e.h, e.m})
        $display("FAIL stall[%0d]: pc=%h vfhm=%b%b%b%b required pc=%h vfhm=%b%b%b%b",
                 k, pc_out, if_valid, flush_ifid, halted, misalign, e.pc, e.v, e.f, e.h, e.m);
      else passed++;
      if (e.cn) begin
        checks++;
        if (npc_out !== e.npc) $display("FAIL stall_npc[%0d]: npc=%h required %h", k, npc_out, e.npc);
        else passed++;
      end
    end
  endtask

  // Continues from pc=0xC left by test_stall.
  task automatic test_redirects();
    st.push_back(mk(0, 0, 1, 32'h40, 1, 0, 32'h40, 32'h0, 0, 0, 1, 0, 0));
    st.push_back(idle(32'h44, 0));
    st.push_back(idle(32'h48, 0));
    st.push_back(mk(1, 32'h100, 1, 32'h40, 0, 0, 32'h100, 32'h0, 0, 0, 1, 0, 0));
    st.push_back(idle(32'h104, 0));
    st.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 0, 1, 0, 0));
    st.push_back(idle(32'h0, 0));
    st.push_back(idle(32'h4, 0));
    for (int k = 0; st.size() > 0; k++) begin
      stim_t s_ = st.pop_front();
      exp_t  e;
      {jump, jump_target, branch_taken, branch_target, stall, halt_req} = {s_.j, s_.jt, s_.b, s_.bt, s_.s, s_.hr};
      sb.push_back(s_.e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_out, if_valid, flush_ifid, halted, misalign} !== {e.pc, e.v, e.f, e.h, e.m})
        $display("FAIL redirect[%0d]: pc=%h vfhm=%b%b%b%b required pc=%h vfhm=%b%b%b%b",
                 k, pc_out, if_valid, flush_ifid, halted, misalign, e.pc, e.v, e.f, e.h, e.m);
      else passed++;
      if (e.cn) begin
        checks++;
        if (npc_out !== e.npc) $display("FAIL redirect_npc[%0d]: npc=%h required %h", k, npc_out, e.npc);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    st.push_back(mk(1, 32'h200, 0, 0, 0, 0, 32'h200, 32'h0, 0, 0, 1, 0, 0));
    st.push_back(mk(0, 0, 1, 32'h300, 0, 0, 32'h300, 32'h0, 0, 0, 1, 0, 0));
    st.push_back(idle(32'h304, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 0, 32'h304, 32'h304, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 1, 32'h400, 1, 0, 32'h400, 32'h0, 0, 0, 1, 0, 0));
    st.push_back(idle(32'h404, 0));
    for (int k = 0; st.size() > 0; k++) begin
      stim_t s_ = st.pop_front();
      exp_t  e;
      {jump, jump_target, branch_taken, branch_target, stall, halt_req} = {s_.j, s_.jt, s_.b, s_.bt, s_.s, s_.hr};
      sb.push_back(s_.e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_out, if_valid, flush_ifid, halted, misalign} !== {e.pc, e.v, e.f, e.h, e.m})
        $display("FAIL b2b[%0d]: pc=%h vfhm=%b%b%b%b required pc=%h vfhm=%b%b%b%b",
                 k, pc_out, if_valid, flush_ifid, halted, misalign, e.pc, e.v, e.f, e.h, e.m);
      else passed++;
      if (e.cn) begin
        checks++;
        if (npc_out !== e.npc) $display("FAIL b2b_npc[%0d]: npc=%h required %h", k, npc_out, e.npc);
        else passed++;
      end
    end
  endtask

  task automatic test_halt();
    st.push_back(mk(1, 32'h20, 0, 0, 0, 0, 32'h20, 32'h0, 0, 0, 1, 0, 0));
    st.push_back(mk(1, 32'h60, 1, 32'h70, 0, 1, 32'h20, 32'h0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 10; i++)
      st.push_back(mk(1'($urandom), 32'h500, 1'($urandom), 32'h600, 1'($urandom), 0,
                      32'h20, 32'h0, 0, 0, 0, 1, 0));
    for (int k = 0; st.size() > 0; k++) begin
      stim_t s_ = st.pop_front();
      exp_t  e;
      {jump, jump_target, branch_taken, branch_target, stall, halt_req} = {s_.j, s_.jt, s_.b, s_.bt, s_.s, s_.hr};
      sb.push_back(s_.e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_out, if_valid, flush_ifid, halted, misalign} !== {e.pc, e.v, e.f, e.h, e.m})
        $display("FAIL halt[%0d]: pc=%h vfhm=%b%b%b%b required pc=%h vfhm=%b%b%b%b",
                 k, pc_out, if_valid, flush_ifid, halted, misalign, e.pc, e.v, e.f, e.h, e.m);
      else passed++;
    end
    // Asynchronous reset asserted away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_out, npc_out, if_valid, flush_ifid, halted, misalign} !== {32'h0, 32'h0, 4'b0000})
      $display("FAIL async_reset: pc=%h npc=%h vfhm=%b%b%b%b required pc=0 npc=0 vfhm=0000",
               pc_out, npc_out, if_valid, flush_ifid, halted, misalign);
    else passed++;
  endtask

  task automatic test_misalign();
    bit trap;
`ifdef PC_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    apply_reset();
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0));
    st.push_back(mk(1, 32'h102, 0, 0, 0, 0, trap ? 32'h80 : 32'h100, 32'h0, 0, 0, 1, 0, trap));
    st.push_back(idle(trap ? 32'h84 : 32'h104, trap));
    st.push_back(mk(0, 0, 1, 32'h41, 0, 0, trap ? 32'h80 : 32'h40, 32'h0, 0, 0, 1, 0, trap));
    st.push_back(mk(1, 32'h200, 0, 0, 0, 0, 32'h200, 32'h0, 0, 0, 1, 0, trap));
    for (int k = 0; st.size() > 0; k++) begin
      stim_t s_ = st.pop_front();
      exp_t  e;
      {jump, jump_target, branch_taken, branch_target, stall, halt_req} = {s_.j, s_.jt, s_.b, s_.bt, s_.s, s_.hr};
      sb.push_back(s_.e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({pc_out, if_valid, flush_ifid, halted, misalign} !== {e.pc, e.v, e.f, e.h, e.m})
        $display("FAIL misalign[%0d]: pc=%h vfhm=%b%b%b%b required pc=%h vfhm=%b%b%b%b",
                 k, pc_out, if_valid, flush_ifid, halted, misalign, e.pc, e.v, e.f, e.h, e.m);
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stall();
    test_redirects();
    test_back_to_back();
    test_halt();
    test_misalign();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
